fetch_unit: RTL and testbench

Instruction fetch stage for the CORG single-issue core. It owns the program counter, issues word requests to instruction memory over a req/ack handshake, and presents each fetched instruction and its 5-bit opcode to the control unit and datapath. It consumes the control unit's `branch`, `jump` and `jump_reg` decisions, already resolved by the datapath, to select the next PC.

---
 rtl/corg_pkg.sv | 27 ++
 rtl/next_pc_sel.sv | 27 ++
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/corg_pkg.sv
// Shared CORG core definitions: field positions, opcodes and the fetch FSM
// state type used by the fetch stage and the control unit.
package corg_pkg;

    localparam int PC_W    = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] OPC_ADD = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_SUB = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_BEQ = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_BNE = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_J   = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_JAL = 5'b00101;

    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

    // Sequential successor; 16-bit unsigned, so 16'hFFFF wraps to 16'h0000.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: register jump beats direct jump beats taken branch
// beats sequential fall-through.
module next_pc_sel
    import corg_pkg::*;
(
    input  logic [PC_W-1:0] instr_pc,
    input  logic            take_branch,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            jump_reg,
    input  logic [PC_W-1:0] reg_target,
    output logic [PC_W-1:0] next_pc
);

    always_comb begin
        next_pc = pc_inc(instr_pc);
        if (jump_reg) begin
            next_pc = reg_target;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (take_branch) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over
// a req/ack handshake and holds it until the datapath accepts it.
module fetch_unit
    import corg_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [PC_W-1:0]  imem_rdata,
    output logic [PC_W-1:0]  instr,
    output logic [OPC_W-1:0] opcode,
    output logic [PC_W-1:0]  instr_pc,
    output logic [PC_W-1:0]  link_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             take_branch,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             jump,
    input  logic [PC_W-1:0]  jump_target,
    input  logic             jump_reg,
    input  logic [PC_W-1:0]  reg_target
);

    fetch_state_t    state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] instr_reg;
    logic [PC_W-1:0] instr_pc_reg;
    logic [PC_W-1:0] pc_next;

    next_pc_sel u_next_pc_sel (
        .instr_pc      (instr_pc_reg),
        .take_branch   (take_branch),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jump_reg      (jump_reg),
        .reg_target    (reg_target),
        .next_pc       (pc_next)
    );

    // Redirects are only consumed on acceptance; no request is in flight
    // during HOLD, so a redirect never costs a wrong-path fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= REQ;
            pc_reg       <= RESET_PC;
            instr_reg    <= '0;
            instr_pc_reg <= RESET_PC;
        end else if (state_reg == REQ) begin
            if (imem_ack) begin
                instr_reg    <= imem_rdata;
                instr_pc_reg <= pc_reg;
                state_reg    <= HOLD;
            end
        end else begin
            if (instr_ready) begin
                pc_reg    <= pc_next;
                state_reg <= REQ;
            end
        end
    end

    assign imem_req    = (state_reg == REQ);
    assign imem_addr   = pc_reg;
    assign instr_valid = (state_reg == HOLD);
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign link_pc     = pc_inc(instr_pc_reg);

    genvar gi;
    generate
        for (gi = 0; gi < OPC_W; gi++) begin : g_opcode
            assign opcode[gi] = instr_reg[OPC_LSB + gi];
        end
    endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level fetch model checked every
// cycle, plus literal expectations for the key addresses and boundary cases.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [4:0]  opcode;
    logic [15:0] instr_pc;
    logic [15:0] link_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        take_branch;
    logic [15:0] branch_target;
    logic        jump;
    logic [15:0] jump_target;
    logic        jump_reg;
    logic [15:0] reg_target;

    int checks = 0;
    int errors = 0;

    // Model: "waiting" means a fetch of m_addr is outstanding; otherwise the
    // instruction m_instr fetched from m_ipc is being presented.
    bit          m_waiting;
    logic [15:0] m_addr;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a < 16'd16) return a;
        return a * 16'h9E37 + 16'h1234;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .opcode        (opcode),
        .instr_pc      (instr_pc),
        .link_pc       (link_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .take_branch   (take_branch),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jump_reg      (jump_reg),
        .reg_target    (reg_target)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("imem_req", {15'd0, imem_req}, {15'd0, m_waiting});
        if (m_waiting) chk("imem_addr", imem_addr, m_addr);
        chk("instr_valid", {15'd0, instr_valid}, {15'd0, !m_waiting});
        chk("instr", instr, m_instr);
        chk("opcode", {11'd0, opcode}, {11'd0, m_instr[15:11]});
        chk("instr_pc", instr_pc, m_ipc);
        chk("link_pc", link_pc, m_ipc + 16'd1);
    endtask

    // Advance one clock: model consumes the inputs seen at the edge, then the
    // DUT outputs are compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_waiting = 1'b1;
            m_addr    = 16'h0000;
            m_instr   = 16'h0000;
            m_ipc     = 16'h0000;
            $display("reset");
        end else if (m_waiting && imem_ack) begin
            m_waiting = 1'b0;
            m_instr   = mem_word(m_addr);
            m_ipc     = m_addr;
            $display("fetch  pc=%h instr=%h", m_ipc, m_instr);
        end else if (!m_waiting && instr_ready) begin
            m_waiting = 1'b1;
            if (jump_reg)         m_addr = reg_target;
            else if (jump)        m_addr = jump_target;
            else if (take_branch) m_addr = branch_target;
            else                  m_addr = m_ipc + 16'd1;
            $display("accept pc=%h next=%h", m_ipc, m_addr);
        end
        #1;
        compare_all();
    endtask

    task automatic clear_redirect();
        take_branch = 0; branch_target = '0;
        jump = 0; jump_target = '0;
        jump_reg = 0; reg_target = '0;
    endtask

    initial begin
        logic [15:0] seen[$];
        rst = 1; imem_ack = 0; instr_ready = 0;
        clear_redirect();
        m_waiting = 1; m_addr = 0; m_instr = 0; m_ipc = 0;

        step(); step();
        rst = 0;
        chk("reset_req", {15'd0, imem_req}, 16'd1);
        chk("reset_addr", imem_addr, 16'h0000);
        chk("reset_valid", {15'd0, instr_valid}, 16'd0);

        // Back-to-back fetch, memory[i] = i
        imem_ack = 1; instr_ready = 1;
        for (int i = 0; i < 8; i++) begin
            if (imem_req) seen.push_back(imem_addr);
            step();
        end
        chk("seq_count", 16'(seen.size()), 16'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            chk("seq_addr", seen[i], 16'(i));

        // Ack delayed 3 cycles at address 4
        imem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr", imem_addr, 16'h0004);
            chk("stall_valid", {15'd0, instr_valid}, 16'd0);
        end
        imem_ack = 1;
        step();
        chk("late_ack_valid", {15'd0, instr_valid}, 16'd1);
        chk("late_ack_ipc", instr_pc, 16'h0004);

        // jump beats take_branch
        imem_ack = 0; instr_ready = 1;
        take_branch = 1; branch_target = 16'h0040;
        jump = 1; jump_target = 16'h0100;
        step();
        chk("jump_prio", imem_addr, 16'h0100);
        imem_ack = 1; step();
        // jump_reg beats both
        imem_ack = 0;
        jump_reg = 1; reg_target = 16'h0200;
        step();
        chk("jreg_prio", imem_addr, 16'h0200);
        clear_redirect();
        imem_ack = 1; step();

        // Hold with ready low; spurious ack in the middle
        instr_ready = 0;
        for (int i = 0; i < 5; i++) begin
            imem_ack = (i == 2);
            step();
            chk("hold_ipc", instr_pc, 16'h0200);
            chk("hold_req", {15'd0, imem_req}, 16'd0);
        end

        // PC wrap at 16'hFFFF
        imem_ack = 0; instr_ready = 1;
        jump_reg = 1; reg_target = 16'hFFFF;
        step();
        clear_redirect();
        imem_ack = 1; step();
        chk("wrap_ipc", instr_pc, 16'hFFFF);
        chk("wrap_link", link_pc, 16'h0000);
        imem_ack = 0; step();
        chk("wrap_addr", imem_addr, 16'h0000);

        // Reset mid-REQ, then a late ack is the RESET_PC fetch
        imem_ack = 1; step();
        imem_ack = 0; jump = 1; jump_target = 16'h0123;
        step();
        clear_redirect();
        step();
        rst = 1; step(); rst = 0;
        chk("rst_req_valid", {15'd0, instr_valid}, 16'd0);
        chk("rst_req_addr", imem_addr, 16'h0000);
        imem_ack = 1; instr_ready = 0;
        step();
        chk("post_rst_ipc", instr_pc, 16'h0000);
        chk("post_rst_valid", {15'd0, instr_valid}, 16'd1);

        // Reset mid-HOLD with a nonzero pending instruction
        instr_ready = 1; imem_ack = 0; step();
        imem_ack = 1; instr_ready = 0; step();
        chk("pre_rst_ipc", instr_pc, 16'h0001);
        rst = 1; step(); rst = 0;
        imem_ack = 0;
        chk("rst_hold_valid", {15'd0, instr_valid}, 16'd0);
        chk("rst_hold_addr", imem_addr, 16'h0000);
        chk("rst_hold_instr", instr, 16'h0000);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
